dose_ack_monitor: RTL and testbench

- Responder to the medicine reminder generator: consumes its `medicine_reminder` level and waits for the patient's acknowledge button.
- Classifies each dose event as taken, taken-late or missed.
- Drives an escalation alarm when the first acknowledge window expires, and keeps saturating dose statistics for the status/display logic.

---
 rtl/dose_ack_monitor.sv | 183 ++++++++++++++++++
 tb/tb_dose_ack_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dose_ack_monitor.sv
// Dose acknowledge monitor: debounces the patient button, times each reminder and classifies
// the dose as taken, late or missed. Optional macro DOSE_LATE_COUNT_EN adds late_cnt/late_pulse.
module dose_ack_monitor #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int ACK_WINDOW      = 200,
  parameter int ESC_WINDOW      = 100,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reminder_in,
  input  logic             ack_btn,
  output logic             alarm,
  output logic             waiting,
  output logic             taken_pulse,
  output logic             missed_pulse,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] missed_cnt,
  output logic             overlap_err,
`ifdef DOSE_LATE_COUNT_EN
  output logic [CNT_W-1:0] late_cnt,
  output logic             late_pulse,
`endif
  output logic [1:0]       dbg_state
);

  localparam int MAX_WIN = (ACK_WINDOW > ESC_WINDOW) ? ACK_WINDOW : ESC_WINDOW;
  localparam int TMR_W   = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_WINDOW - 1);
  localparam logic [TMR_W-1:0] ESC_LAST = TMR_W'(ESC_WINDOW - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ESCALATE = 2'd2
  } state_t;

  // Button path: 2-flop synchronizer, then a debouncer counting consecutive differing samples.
  logic            sync1_q, sync2_q;
  logic            db_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            ack_pulse_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_cnt_q    <= '0;
      ack_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= ack_btn;
      sync2_q     <= sync1_q;
      ack_pulse_q <= 1'b0;
      if (sync2_q != db_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_q        <= sync2_q;
          db_cnt_q    <= '0;
          ack_pulse_q <= sync2_q;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  logic rem_q;
  logic rise;
  assign rise = reminder_in & ~rem_q;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             taken_d, missed_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    taken_d  = 1'b0;
    missed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = WAIT_ACK;
          timer_d = '0;
        end
      end
      WAIT_ACK: begin
        // An ack arriving together with window expiry still counts as taken.
        if (ack_pulse_q) begin
          taken_d = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == ACK_LAST) begin
          state_d = ESCALATE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ESCALATE: begin
        if (ack_pulse_q) begin
          taken_d = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == ESC_LAST) begin
          missed_d = 1'b1;
          state_d  = IDLE;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  logic             alarm_q, waiting_q, taken_pulse_q, missed_pulse_q, overlap_q;
  logic [CNT_W-1:0] taken_cnt_q, missed_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      rem_q          <= 1'b0;
      alarm_q        <= 1'b0;
      waiting_q      <= 1'b0;
      taken_pulse_q  <= 1'b0;
      missed_pulse_q <= 1'b0;
      taken_cnt_q    <= '0;
      missed_cnt_q   <= '0;
      overlap_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      rem_q          <= reminder_in;
      alarm_q        <= (state_d == ESCALATE);
      waiting_q      <= (state_d != IDLE);
      taken_pulse_q  <= taken_d;
      missed_pulse_q <= missed_d;
      if (taken_d && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      if (missed_d && (missed_cnt_q != '1)) missed_cnt_q <= missed_cnt_q + CNT_W'(1);
      // A rise seen outside IDLE (including the cycle of return) is dropped but flagged.
      if (rise && (state_q != IDLE)) overlap_q <= 1'b1;
    end
  end

`ifdef DOSE_LATE_COUNT_EN
  logic             late_pulse_q;
  logic [CNT_W-1:0] late_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      late_pulse_q <= 1'b0;
      late_cnt_q   <= '0;
    end else begin
      late_pulse_q <= taken_d && (state_q == ESCALATE);
      if (taken_d && (state_q == ESCALATE) && (late_cnt_q != '1))
        late_cnt_q <= late_cnt_q + CNT_W'(1);
    end
  end

  assign late_pulse = late_pulse_q;
  assign late_cnt   = late_cnt_q;
`endif

  assign alarm        = alarm_q;
  assign waiting      = waiting_q;
  assign taken_pulse  = taken_pulse_q;
  assign missed_pulse = missed_pulse_q;
  assign taken_cnt    = taken_cnt_q;
  assign missed_cnt   = missed_cnt_q;
  assign overlap_err  = overlap_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dose_ack_monitor.sv
// Directed bench for dose_ack_monitor (DEBOUNCE_CYCLES=4, ACK_WINDOW=20, ESC_WINDOW=10, CNT_W=4).
module tb_dose_ack_monitor;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             reminder_in;
  logic             ack_btn;
  logic             alarm, waiting, taken_pulse, missed_pulse, overlap_err;
  logic [CNT_W-1:0] taken_cnt, missed_cnt;
  logic [1:0]       dbg_state;
`ifdef DOSE_LATE_COUNT_EN
  logic [CNT_W-1:0] late_cnt;
  logic             late_pulse;
`endif

  dose_ack_monitor #(
    .DEBOUNCE_CYCLES(4),
    .ACK_WINDOW     (20),
    .ESC_WINDOW     (10),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .reminder_in (reminder_in),
    .ack_btn     (ack_btn),
    .alarm       (alarm),
    .waiting     (waiting),
    .taken_pulse (taken_pulse),
    .missed_pulse(missed_pulse),
    .taken_cnt   (taken_cnt),
    .missed_cnt  (missed_cnt),
    .overlap_err (overlap_err),
`ifdef DOSE_LATE_COUNT_EN
    .late_cnt    (late_cnt),
    .late_pulse  (late_pulse),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: expected event codes, 1 = taken, 2 = missed
  logic [1:0] exp_q[$];
  int taken_seen  = 0;
  int missed_seen = 0;

  always @(negedge clk) begin
    logic [1:0] ev;
    if (taken_pulse || missed_pulse) begin
      ev = {missed_pulse, taken_pulse};
      if (taken_pulse) taken_seen++;
      if (missed_pulse) missed_seen++;
      if (exp_q.size() == 0) chk("unexpected_event", ev, 0);
      else chk("event_kind", ev, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    reminder_in = 1'b0;
    ack_btn     = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic rise_rem();
    reminder_in = 1'b1;
    tick(1);
    reminder_in = 1'b0;
  endtask

  task automatic wait_taken(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (taken_pulse) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  w, a, first_a, miss_idx, missed_base;
    bit  found;

    do_reset();
    chk("rst_alarm", alarm, 0);
    chk("rst_waiting", waiting, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    chk("rst_missed_cnt", missed_cnt, 0);
    chk("rst_overlap", overlap_err, 0);
    chk("rst_state", dbg_state, 0);

    // On-time ack
    rise_rem();
    chk("t1_waiting", waiting, 1);
    chk("t1_alarm", alarm, 0);
    tick(4);
    ack_btn = 1'b1;
    tick(6);
    chk("t1_no_pulse_yet", taken_pulse, 0);
    chk("t1_still_waiting", waiting, 1);
    exp_q.push_back(2'd1);
    tick(1);
    chk("t1_taken_pulse", taken_pulse, 1);
    chk("t1_taken_cnt", taken_cnt, 1);
    chk("t1_waiting_low", waiting, 0);
    chk("t1_alarm_low", alarm, 0);
    tick(1);
    chk("t1_pulse_width", taken_pulse, 0);
    ack_btn = 1'b0;
    tick(8);

    // Missed dose: 20 cycles waiting, then 10 cycles of alarm
    exp_q.push_back(2'd2);
    rise_rem();
    w = 0; a = 0; first_a = -1; miss_idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (waiting) w++;
      if (alarm) begin
        a++;
        if (first_a < 0) first_a = i;
      end
      if (missed_pulse && miss_idx < 0) miss_idx = i;
      tick(1);
    end
    chk("t2_wait_cycles", w, 30);
    chk("t2_alarm_cycles", a, 10);
    chk("t2_alarm_start", first_a, 20);
    chk("t2_missed_at", miss_idx, 30);
    chk("t2_missed_cnt", missed_cnt, 1);
    chk("t2_alarm_off", alarm, 0);

    // Bounce rejection: 3-cycle glitches give no ack
    rise_rem();
    for (int g = 0; g < 2; g++) begin
      ack_btn = 1'b1;
      tick(3);
      ack_btn = 1'b0;
      tick(3);
    end
    chk("t3_no_take", taken_cnt, 1);
    chk("t3_still_waiting", waiting, 1);
    exp_q.push_back(2'd1);
    ack_btn = 1'b1;
    wait_taken(12, found);
    chk("t3_found", found, 1);
    chk("t3_taken_cnt", taken_cnt, 2);
    chk("t3_not_late", alarm, 0);
    ack_btn = 1'b0;
    tick(8);

    // Late ack in ESCALATE
    rise_rem();
    tick(20);
    chk("t4_alarm_on", alarm, 1);
    ack_btn = 1'b1;
    tick(6);
    chk("t4_alarm_still", alarm, 1);
    chk("t4_no_pulse_yet", taken_pulse, 0);
    exp_q.push_back(2'd1);
    tick(1);
    chk("t4_taken_pulse", taken_pulse, 1);
    chk("t4_alarm_drop", alarm, 0);
    chk("t4_taken_cnt", taken_cnt, 3);
`ifdef DOSE_LATE_COUNT_EN
    chk("t4_late_pulse", late_pulse, 1);
    chk("t4_late_cnt", late_cnt, 1);
`endif
    tick(1);
`ifdef DOSE_LATE_COUNT_EN
    chk("t4_late_pulse_width", late_pulse, 0);
`endif
    ack_btn = 1'b0;
    tick(8);

    // Ack lands on the last escalation cycle: taken wins over missed
    rise_rem();
    tick(23);
    ack_btn = 1'b1;
    exp_q.push_back(2'd1);
    tick(7);
    chk("t5_taken_pulse", taken_pulse, 1);
    chk("t5_no_missed", missed_pulse, 0);
    chk("t5_missed_cnt", missed_cnt, 1);
    chk("t5_taken_cnt", taken_cnt, 4);
`ifdef DOSE_LATE_COUNT_EN
    chk("t5_late_cnt", late_cnt, 2);
`endif
    ack_btn = 1'b0;
    tick(8);

    // Overlap: second rise during WAIT_ACK, first event still resolves
    do_reset();
    chk("t6_rst_taken", taken_cnt, 0);
    exp_q.push_back(2'd2);
    rise_rem();
    tick(2);
    rise_rem();
    chk("t6_overlap_set", overlap_err, 1);
    chk("t6_state_wait", dbg_state, 1);
    tick(26);
    chk("t6_no_miss_yet", missed_pulse, 0);
    chk("t6_alarm", alarm, 1);
    tick(1);
    chk("t6_missed_pulse", missed_pulse, 1);
    chk("t6_missed_cnt", missed_cnt, 1);
    tick(2);
    chk("t6_overlap_sticky", overlap_err, 1);
    chk("t6_idle", waiting, 0);

    // Saturation: 17 missed doses
    do_reset();
    chk("t7_overlap_cleared", overlap_err, 0);
    missed_base = missed_seen;
    for (int d = 0; d < 17; d++) begin
      exp_q.push_back(2'd2);
      rise_rem();
      tick(31);
      if (d == 14) chk("t7_cnt_at_15", missed_cnt, 15);
    end
    chk("t7_missed_sat", missed_cnt, 15);
    chk("t7_pulses", missed_seen - missed_base, 17);
    chk("t7_no_overlap", overlap_err, 0);

    // Reset mid-event during ESCALATE
    rise_rem();
    tick(1);
    rise_rem();
    tick(22);
    chk("t8_alarm_on", alarm, 1);
    chk("t8_overlap_on", overlap_err, 1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("t8_alarm", alarm, 0);
    chk("t8_waiting", waiting, 0);
    chk("t8_missed_cnt", missed_cnt, 0);
    chk("t8_taken_cnt", taken_cnt, 0);
    chk("t8_overlap", overlap_err, 0);
    chk("t8_state", dbg_state, 0);
    ack_btn = 1'b1;
    tick(12);
    ack_btn = 1'b0;
    tick(8);
    chk("t8_idle_ack_ignored", taken_cnt, 0);
    chk("t8_still_idle", dbg_state, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
